score_ctrl: RTL and testbench
=============================

Name: score_ctrl

Overview:
- Scoreboard controller for the pong top level.
- Owns both player scores and sequences the two digital_ssd score renderers: per-digit value, colour and visibility.
- Runs the point-hold and win-flash timing from a one-cycle frame tick.
- Sits between the game logic (point events) and the digital_ssd instances / rendering block.

Parameters:
- WIN_SCORE, 9, score that ends the game (1..9, since the display is one decimal digit).
- HOLD_TICKS, 60, ticks play is frozen after a point.
- FLASH_TICKS, 15, ticks per flash half-period.
- NUM_FLASHES, 6, number of full on/off flash cycles before OVER.
- COLOR_NORMAL, 8'hFF, RRRGGGBB colour of a digit during play.
- COLOR_WIN, 8'h1C, RRRGGGBB colour of the winner digit in FLASH and OVER.

Ports:
- clk  in  1  pixel-domain clock (same clk as digital_ssd).
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle frame strobe; all timers advance only on tick.
- point_left  in  1  one-cycle pulse: left player scored.
- point_right  in  1  one-cycle pulse: right player scored.
- new_game  in  1  one-cycle pulse: clear scores and start play.
- left_value  out  4  Value for the left digital_ssd.
- right_value  out  4  Value for the right digital_ssd.
- left_color  out  8  colour for the left digit.
- right_color  out  8  colour for the right digit.
- left_visible  out  1  gate for LeftSSDHit.
- right_visible  out  1  gate for RightSSDHit.
- play_en  out  1  high only in PLAY; game logic moves the ball only when high.
- serve_right  out  1  1 means the next serve goes toward the right player.
- game_over  out  1  high in FLASH and OVER.

Behaviour:
- Clocking and reset
  - All state changes on posedge clk.
  - reset_n low asynchronously forces: state IDLE, scores 0, timers 0.
  - Outputs under reset: values 0, colours COLOR_NORMAL, visible 1, play_en 0, serve_right 0, game_over 0.
  - Reset mid-FLASH or mid-HOLD aborts the sequence immediately.
- Registered outputs
  - All outputs are registered.
  - A score change appears on *_value exactly 1 clk after the point pulse is sampled.
- States: IDLE, PLAY, HOLD, FLASH, OVER.
- IDLE
  - Shows 0/0, both digits visible.
  - new_game leads to PLAY.
- PLAY
  - point_left alone: left score +1, serve_right=1.
  - point_right alone: right score +1, serve_right=0.
  - If the new score equals WIN_SCORE, go to FLASH; otherwise go to HOLD.
  - point_left and point_right in the same cycle: neither scores, state unchanged.
- HOLD
  - play_en=0; point pulses ignored.
  - After HOLD_TICKS ticks, return to PLAY.
  - The hold counter counts ticks 0..HOLD_TICKS-1 and transitions on the tick at HOLD_TICKS-1.
- FLASH
  - Winner colour is COLOR_WIN.
  - Winner visibility toggles every FLASH_TICKS ticks, starting visible.
  - After 2*NUM_FLASHES half-periods, go to OVER with the winner visible.
  - Loser digit stays steady at COLOR_NORMAL.
- OVER
  - Steady display; waits for new_game.
- new_game precedence
  - new_game in any non-reset state: scores cleared to 0, timers cleared, go to PLAY.
  - Takes priority over a point pulse in the same cycle.
- Counting rules
  - Scores never exceed WIN_SCORE; no wrap.
  - tick and an event in the same cycle: the event is processed and the tick advances the timer of the current state.

Optional Feature:
- Macro: SCORE_ATTRACT_EN.
- With the macro defined: in IDLE both values count 0..9 in lockstep, advancing every FLASH_TICKS ticks and wrapping 9 to 0. Entering PLAY restores both to 0.
- Without it: IDLE shows a static 0/0.

Decomposition:
- Shared package pong_pkg holds:
  - score_state_t enum (IDLE, PLAY, HOLD, FLASH, OVER).
  - SCORE_W=4.
  - COLOR_W=8.
  - Default colour constants.
- One sub-module, tick_timer:
  - Loadable tick-qualified down-counter.
  - Interface: clk, reset_n, tick, load, load_val, expired.
  - Reused for the HOLD, FLASH and attract timers.

Test Plan:
- Reset: assert reset_n=0 mid-FLASH -> next cycle state IDLE, values 0/0, colours 8'hFF, play_en=0.
- Single point: new_game, then point_left -> 1 clk later left_value=1, serve_right=1, play_en=0. After 60 ticks play_en=1; a point_right during HOLD is ignored.
- Simultaneous points: point_left and point_right in the same cycle while in PLAY -> scores unchanged, still PLAY.
- Win: drive right to 9 -> game_over=1, right_color=8'h1C, right_visible toggles every 15 ticks for 12 half-periods, then steady 1 in OVER.
- new_game priority: new_game together with point_left in OVER -> scores 0/0, PLAY, game_over=0.
- SCORE_ATTRACT_EN defined: stay in IDLE for 150 ticks -> values step 0..9 and wrap to 0; new_game -> 0/0.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong scoreboard: state encoding, widths
// and default digit colours.
package pong_pkg;

  localparam int SCORE_W = 4;
  localparam int COLOR_W = 8;
  localparam int TICK_W  = 16;

  localparam logic [COLOR_W-1:0] COLOR_NORMAL_DEF = 8'hFF;
  localparam logic [COLOR_W-1:0] COLOR_WIN_DEF    = 8'h1C;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_FLASH = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    PLAY  = S_PLAY,
    HOLD  = S_HOLD,
    FLASH = S_FLASH,
    OVER  = S_OVER
  } score_state_t;

  function automatic logic is_finished(input score_state_t s);
    return (s == FLASH) || (s == OVER);
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter that only moves on the frame tick; expired pulses on
// a tick seen while the count is already zero.
module tick_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = tick && (cnt_q == '0);

endmodule

// File: rtl/score_ctrl.sv
// Pong scoreboard controller: owns both scores, point-hold and win-flash timing.
// Optional SCORE_ATTRACT_EN: IDLE digits cycle 0..9 every FLASH_TICKS ticks.
//
// state | meaning
// IDLE  | power-up, 0/0 shown (or attract cycling), waiting for new_game
// PLAY  | ball in play, point pulses score
// HOLD  | play frozen for HOLD_TICKS ticks after a point
// FLASH | winner digit blinks in COLOR_WIN
// OVER  | steady final score, waiting for new_game
module score_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int HOLD_TICKS  = 60,
  parameter int FLASH_TICKS = 15,
  parameter int NUM_FLASHES = 6,
  parameter logic [COLOR_W-1:0] COLOR_NORMAL = COLOR_NORMAL_DEF,
  parameter logic [COLOR_W-1:0] COLOR_WIN    = COLOR_WIN_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               point_left,
  input  logic               point_right,
  input  logic               new_game,
  output logic [SCORE_W-1:0] left_value,
  output logic [SCORE_W-1:0] right_value,
  output logic [COLOR_W-1:0] left_color,
  output logic [COLOR_W-1:0] right_color,
  output logic               left_visible,
  output logic               right_visible,
  output logic               play_en,
  output logic               serve_right,
  output logic               game_over
);

  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [TICK_W-1:0]  HOLD_LOAD  = TICK_W'(HOLD_TICKS - 1);
  localparam logic [TICK_W-1:0]  FLASH_LOAD = TICK_W'(FLASH_TICKS - 1);
  localparam logic [7:0]         LAST_HALF  = 8'(2 * NUM_FLASHES - 1);

  score_state_t       state_q, state_d;
  logic [SCORE_W-1:0] lscore_q, lscore_d, rscore_q, rscore_d;
  logic [SCORE_W-1:0] l_inc, r_inc;
  logic               serve_q, serve_d;
  logic               winner_left_q, winner_left_d;
  logic               win_vis_q, win_vis_d;
  logic [7:0]         half_q, half_d;
  logic [COLOR_W-1:0] left_color_q, left_color_d, right_color_q, right_color_d;
  logic               left_vis_q, left_vis_d, right_vis_q, right_vis_d;
  logic               play_en_q, play_en_d, game_over_q, game_over_d;
  logic               finished;
  logic               timer_load;
  logic [TICK_W-1:0]  timer_val;
  logic               timer_exp;

  assign l_inc = lscore_q + 1'b1;
  assign r_inc = rscore_q + 1'b1;

  tick_timer #(.W(TICK_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_exp)
  );

  always_comb begin
    state_d       = state_q;
    lscore_d      = lscore_q;
    rscore_d      = rscore_q;
    serve_d       = serve_q;
    winner_left_d = winner_left_q;
    win_vis_d     = win_vis_q;
    half_d        = half_q;
    timer_load    = 1'b0;
    timer_val     = '0;
    case (state_q)
      IDLE: begin
`ifdef SCORE_ATTRACT_EN
        if (timer_exp) begin
          lscore_d   = (lscore_q == 4'd9) ? '0 : l_inc;
          rscore_d   = (rscore_q == 4'd9) ? '0 : r_inc;
          timer_load = 1'b1;
          timer_val  = FLASH_LOAD;
        end
`endif
      end
      PLAY: begin
        if (point_left ^ point_right) begin
          timer_load = 1'b1;
          half_d     = '0;
          win_vis_d  = 1'b1;
          if (point_left) begin
            lscore_d = l_inc;
            serve_d  = 1'b1;
          end else begin
            rscore_d = r_inc;
            serve_d  = 1'b0;
          end
          if ((point_left ? l_inc : r_inc) == WIN_VAL) begin
            state_d       = FLASH;
            winner_left_d = point_left;
            timer_val     = FLASH_LOAD;
          end else begin
            state_d   = HOLD;
            timer_val = HOLD_LOAD;
          end
        end
      end
      HOLD: begin
        if (timer_exp) state_d = PLAY;
      end
      FLASH: begin
        if (timer_exp) begin
          timer_load = 1'b1;
          timer_val  = FLASH_LOAD;
          if (half_q == LAST_HALF) begin
            state_d   = OVER;
            win_vis_d = 1'b1;
          end else begin
            half_d    = half_q + 1'b1;
            win_vis_d = ~win_vis_q;
          end
        end
      end
      default: ;
    endcase
    // new_game overrides whatever the current state decided this cycle
    if (new_game) begin
      state_d    = PLAY;
      lscore_d   = '0;
      rscore_d   = '0;
      half_d     = '0;
      win_vis_d  = 1'b1;
      timer_load = 1'b1;
      timer_val  = '0;
    end
  end

  assign finished      = is_finished(state_d);
  assign left_color_d  = (finished && winner_left_d)  ? COLOR_WIN : COLOR_NORMAL;
  assign right_color_d = (finished && !winner_left_d) ? COLOR_WIN : COLOR_NORMAL;
  assign left_vis_d    = !(finished && winner_left_d)  || win_vis_d;
  assign right_vis_d   = !(finished && !winner_left_d) || win_vis_d;
  assign play_en_d     = (state_d == PLAY);
  assign game_over_d   = finished;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      lscore_q      <= '0;
      rscore_q      <= '0;
      serve_q       <= 1'b0;
      winner_left_q <= 1'b0;
      win_vis_q     <= 1'b1;
      half_q        <= '0;
      left_color_q  <= COLOR_NORMAL;
      right_color_q <= COLOR_NORMAL;
      left_vis_q    <= 1'b1;
      right_vis_q   <= 1'b1;
      play_en_q     <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lscore_q      <= lscore_d;
      rscore_q      <= rscore_d;
      serve_q       <= serve_d;
      winner_left_q <= winner_left_d;
      win_vis_q     <= win_vis_d;
      half_q        <= half_d;
      left_color_q  <= left_color_d;
      right_color_q <= right_color_d;
      left_vis_q    <= left_vis_d;
      right_vis_q   <= right_vis_d;
      play_en_q     <= play_en_d;
      game_over_q   <= game_over_d;
    end
  end

  assign left_value    = lscore_q;
  assign right_value   = rscore_q;
  assign left_color    = left_color_q;
  assign right_color   = right_color_q;
  assign left_visible  = left_vis_q;
  assign right_visible = right_vis_q;
  assign play_en       = play_en_q;
  assign serve_right   = serve_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed game scenarios plus random point/tick traffic,
// all outputs compared every cycle against a tick-counting behavioural model.
module tb_score_ctrl;

  localparam int WIN_SCORE   = 9;
  localparam int HOLD_TICKS  = 60;
  localparam int FLASH_TICKS = 15;
  localparam int NUM_FLASHES = 6;

  localparam int M_IDLE = 0, M_PLAY = 1, M_HOLD = 2, M_FLASH = 3, M_OVER = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0, point_left = 1'b0, point_right = 1'b0, new_game = 1'b0;
  logic [3:0] left_value, right_value;
  logic [7:0] left_color, right_color;
  logic       left_visible, right_visible, play_en, serve_right, game_over;

  int n_cmp = 0;
  int n_err = 0;

  // model: phase, scores, and ticks elapsed since the current phase began
  int m_mode, m_l, m_r, m_seen;
  bit m_serve, m_wl;

  always #5 clk = ~clk;

  score_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .point_left   (point_left),
    .point_right  (point_right),
    .new_game     (new_game),
    .left_value   (left_value),
    .right_value  (right_value),
    .left_color   (left_color),
    .right_color  (right_color),
    .left_visible (left_visible),
    .right_visible(right_visible),
    .play_en      (play_en),
    .serve_right  (serve_right),
    .game_over    (game_over)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_l = 0; m_r = 0; m_seen = 0; m_serve = 0; m_wl = 0;
  endtask

  task automatic model_step(input bit ng, input bit pl, input bit pr, input bit tk);
    if (ng) begin
      m_mode = M_PLAY; m_l = 0; m_r = 0; m_seen = 0;
      return;
    end
    case (m_mode)
      M_PLAY: if (pl != pr) begin
        if (pl) begin m_l++; m_serve = 1; end
        else    begin m_r++; m_serve = 0; end
        m_seen = 0;
        if (m_l == WIN_SCORE || m_r == WIN_SCORE) begin
          m_mode = M_FLASH; m_wl = pl;
        end else begin
          m_mode = M_HOLD;
        end
      end
      M_HOLD: if (tk) begin
        m_seen++;
        if (m_seen == HOLD_TICKS) m_mode = M_PLAY;
      end
      M_FLASH: if (tk) begin
        m_seen++;
        if (m_seen == FLASH_TICKS * 2 * NUM_FLASHES) m_mode = M_OVER;
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    bit fin, wvis;
    fin  = (m_mode == M_FLASH) || (m_mode == M_OVER);
    wvis = (m_mode == M_OVER) || (((m_seen / FLASH_TICKS) % 2) == 0);
    chk("left_value",  left_value,  m_l);
    chk("right_value", right_value, m_r);
    chk("left_color",  left_color,  (fin && m_wl)  ? 8'h1C : 8'hFF);
    chk("right_color", right_color, (fin && !m_wl) ? 8'h1C : 8'hFF);
    chk("left_visible",  left_visible,  (fin && m_wl)  ? wvis : 1'b1);
    chk("right_visible", right_visible, (fin && !m_wl) ? wvis : 1'b1);
    chk("play_en",     play_en,     m_mode == M_PLAY);
    chk("serve_right", serve_right, m_serve);
    chk("game_over",   game_over,   fin);
  endtask

  // called just after a negedge; returns just after the following negedge
  task automatic cycle(input bit ng, input bit pl, input bit pr, input bit tk);
    new_game = ng; point_left = pl; point_right = pr; tick = tk;
    @(posedge clk);
    model_step(ng, pl, pr, tk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    new_game = 0; point_left = 0; point_right = 0; tick = 0;
    reset_n = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    reset_n = 1;
    check_outputs();
  endtask

  task automatic score_to_win(input bit left_side);
    for (int i = 0; i < WIN_SCORE; i++) begin
      cycle(0, left_side, !left_side, 0);
      if (i < WIN_SCORE - 1) repeat (HOLD_TICKS) cycle(0, 0, 0, 1);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset_n = 1;
    repeat (3) cycle(0, 0, 0, 1);

    cycle(1, 0, 0, 0);
    chk("ng_play_en", play_en, 1'b1);
    cycle(0, 1, 1, 1);
    chk("simul_keep_play", play_en, 1'b1);
    cycle(0, 1, 0, 0);
    chk("pt_left_value", left_value, 4'd1);
    chk("pt_left_serve", serve_right, 1'b1);
    cycle(0, 0, 1, 1);
    repeat (HOLD_TICKS - 2) cycle(0, 0, 0, 1);
    chk("hold_not_done", play_en, 1'b0);
    cycle(0, 0, 0, 1);
    chk("hold_done", play_en, 1'b1);
    chk("hold_ignored_right", right_value, 4'd0);

    cycle(1, 0, 0, 0);
    score_to_win(1'b0);
    chk("win_game_over", game_over, 1'b1);
    chk("win_color", right_color, 8'h1C);
    repeat (FLASH_TICKS * 2 * NUM_FLASHES + 10) cycle(0, 0, 0, 1);
    chk("over_visible", right_visible, 1'b1);
    cycle(1, 1, 0, 1);
    chk("ng_prio_left", left_value, 4'd0);
    chk("ng_prio_over", game_over, 1'b0);

    score_to_win(1'b1);
    repeat (FLASH_TICKS + 5) cycle(0, 0, 0, 1);
    chk("mid_flash_hidden", left_visible, 1'b0);
    do_reset();
    repeat (2) cycle(0, 0, 0, 1);

    for (int n = 0; n < 30000; n++) begin
      if ($urandom_range(4999) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(2999) == 0, $urandom_range(5) == 0,
              $urandom_range(5) == 0, $urandom_range(1) == 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
